// File: rtl/irq_ctrl.sv
// irq_ctrl: latches rising edges on NUM_IRQ request lines into a pending
// register, gates them with a software mask and raises a single interrupt
// request toward the CPU control unit. On acknowledge it picks the
// lowest-index enabled pending line, reports VECTOR_BASE+index and locks
// out further requests until end-of-interrupt.
//
// Ports:
//   I_clk, I_reset       clock, synchronous active-high reset
//   I_irq_lines          peripheral request levels (rising edge = request)
//   I_mask_we/I_mask_data mask register write
//   I_irq_ack            acknowledge pulse from control unit
//   I_eoi                end-of-interrupt pulse
//   O_irq_active         interrupt request toward control unit
//   O_irq_number         vector of the last acknowledged line
//   O_irq_number_valid   one-cycle strobe after an acknowledge
//   O_pending, O_mask    register readback
module irq_ctrl #(
  parameter int unsigned NUM_IRQ     = 8,
  parameter logic [15:0] VECTOR_BASE = 16'h0010
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic [NUM_IRQ-1:0] I_irq_lines,
  input  logic               I_mask_we,
  input  logic [NUM_IRQ-1:0] I_mask_data,
  input  logic               I_irq_ack,
  input  logic               I_eoi,
  output logic               O_irq_active,
  output logic [15:0]        O_irq_number,
  output logic               O_irq_number_valid,
  output logic [NUM_IRQ-1:0] O_pending,
  output logic [NUM_IRQ-1:0] O_mask
);

  typedef enum logic [1:0] {IDLE, ARMED, SERVE, WAIT_EOI} state_t;

  state_t state, state_nxt;

  logic [NUM_IRQ-1:0] prev_p0;
  logic [NUM_IRQ-1:0] pending_p0;
  logic [NUM_IRQ-1:0] mask_p0;
  logic [15:0]        number_p0;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] winner;
  logic [NUM_IRQ-1:0] clr;
  logic [3:0]         win_idx;
  logic               take;

  // Lowest set bit wins; the descending loop leaves the lowest index last.
  function automatic logic [3:0] low_index(input logic [NUM_IRQ-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [NUM_IRQ-1:0] low_onehot(input logic [NUM_IRQ-1:0] v);
    logic [NUM_IRQ-1:0] oh;
    oh = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  // Vector number wraps modulo 2^16.
  function automatic logic [15:0] vector_of(input logic [3:0] idx);
    return VECTOR_BASE + {12'd0, idx};
  endfunction

  assign rise     = I_irq_lines & ~prev_p0;
  assign eligible = pending_p0 & mask_p0;
  assign winner   = low_onehot(eligible);
  assign win_idx  = low_index(eligible);
  // An ack that finds nothing eligible (mask removed it) selects nothing.
  assign take     = (state == ARMED) && I_irq_ack && (eligible != '0);
  assign clr      = take ? winner : '0;

  always_ff @(posedge I_clk) begin
    if (I_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    O_irq_active       = 1'b0;
    O_irq_number_valid = 1'b0;
    case (state)
      IDLE: begin
        if (eligible != '0) state_nxt = ARMED;
      end
      ARMED: begin
        O_irq_active = 1'b1;
        if (take)                 state_nxt = SERVE;
        else if (eligible == '0)  state_nxt = IDLE;
      end
      SERVE: begin
        O_irq_number_valid = 1'b1;
        state_nxt          = WAIT_EOI;
      end
      WAIT_EOI: begin
        if (I_eoi) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: edge history, pending/mask registers and latched vector.
  // A new edge on the winner in the ack cycle re-sets its bit (set wins).
  always_ff @(posedge I_clk) begin
    prev_p0 <= I_irq_lines;
    if (I_reset) begin
      pending_p0 <= '0;
      mask_p0    <= '0;
      number_p0  <= 16'h0000;
    end else begin
      pending_p0 <= (pending_p0 & ~clr) | rise;
      if (I_mask_we) mask_p0   <= I_mask_data;
      if (take)      number_p0 <= vector_of(win_idx);
    end
  end

  assign O_irq_number = number_p0;
  assign O_pending    = pending_p0;
  assign O_mask       = mask_p0;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed-vector bench for irq_ctrl. Instance a uses the
// default parameters; instance b uses NUM_IRQ=4, VECTOR_BASE=16'hFFFE to
// exercise vector wrap-around.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic [7:0]  a_lines, a_mask_data, a_pending, a_mask;
  logic        a_mask_we, a_ack, a_eoi, a_active, a_valid;
  logic [15:0] a_number;

  logic [3:0]  b_lines, b_mask_data, b_pending, b_mask;
  logic        b_mask_we, b_ack, b_eoi, b_active, b_valid;
  logic [15:0] b_number;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.NUM_IRQ(8), .VECTOR_BASE(16'h0010)) u_a (
    .I_clk(clk), .I_reset(rst), .I_irq_lines(a_lines),
    .I_mask_we(a_mask_we), .I_mask_data(a_mask_data),
    .I_irq_ack(a_ack), .I_eoi(a_eoi),
    .O_irq_active(a_active), .O_irq_number(a_number),
    .O_irq_number_valid(a_valid), .O_pending(a_pending), .O_mask(a_mask)
  );

  irq_ctrl #(.NUM_IRQ(4), .VECTOR_BASE(16'hFFFE)) u_b (
    .I_clk(clk), .I_reset(rst), .I_irq_lines(b_lines),
    .I_mask_we(b_mask_we), .I_mask_data(b_mask_data),
    .I_irq_ack(b_ack), .I_eoi(b_eoi),
    .O_irq_active(b_active), .O_irq_number(b_number),
    .O_irq_number_valid(b_valid), .O_pending(b_pending), .O_mask(b_mask)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_mask(input logic [7:0] m);
    a_mask_we   = 1'b1;
    a_mask_data = m;
    tick();
    a_mask_we   = 1'b0;
  endtask

  task automatic ack_a();
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
  endtask

  task automatic eoi_a();
    a_eoi = 1'b1;
    tick();
    a_eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_lines = '0; a_mask_we = 1'b0; a_mask_data = '0; a_ack = 1'b0; a_eoi = 1'b0;
    b_lines = '0; b_mask_we = 1'b0; b_mask_data = '0; b_ack = 1'b0; b_eoi = 1'b0;
    tick(2);
    rst = 1'b0;
    tick();
    chk("rst_active", a_active, 0);
    chk("rst_number", a_number, 16'h0000);
    chk("rst_valid", a_valid, 0);
    chk("rst_pending", a_pending, 8'h00);
    chk("rst_mask", a_mask, 8'h00);

    // Single line, 2-cycle latency to active, ack gives 0x12.
    write_mask(8'h04);
    chk("t1_mask", a_mask, 8'h04);
    a_lines = 8'h04;
    tick();
    chk("t1_pend_set", a_pending, 8'h04);
    chk("t1_active_early", a_active, 0);
    tick();
    chk("t1_active", a_active, 1);
    a_lines = 8'h00;
    ack_a();
    chk("t1_number", a_number, 16'h0012);
    chk("t1_valid", a_valid, 1);
    chk("t1_pend_clr", a_pending, 8'h00);
    chk("t1_active_drop", a_active, 0);
    tick();
    chk("t1_valid_once", a_valid, 0);
    chk("t1_number_hold", a_number, 16'h0012);
    eoi_a();

    // Two simultaneous lines: lower index first, the other after EOI.
    write_mask(8'hFF);
    a_lines = 8'h28;
    tick();
    chk("t2_pend", a_pending, 8'h28);
    a_lines = 8'h00;
    tick();
    chk("t2_active", a_active, 1);
    ack_a();
    chk("t2_number", a_number, 16'h0013);
    chk("t2_pend_left", a_pending, 8'h20);
    tick(2);
    chk("t2_locked", a_active, 0);
    eoi_a();
    chk("t2_idle_after_eoi", a_active, 0);
    tick();
    chk("t2_rearm", a_active, 1);
    ack_a();
    chk("t2_number2", a_number, 16'h0015);
    chk("t2_pend_empty", a_pending, 8'h00);
    tick();
    eoi_a();

    // Masked pending line, then enable, then mask away while armed.
    write_mask(8'h00);
    a_lines = 8'h02;
    tick();
    a_lines = 8'h00;
    tick(2);
    chk("t3_masked_inactive", a_active, 0);
    chk("t3_masked_pend", a_pending, 8'h02);
    write_mask(8'h02);
    tick();
    chk("t3_enabled_active", a_active, 1);
    write_mask(8'h00);
    tick();
    chk("t3_masked_away", a_active, 0);
    chk("t3_pend_kept", a_pending, 8'h02);

    // Line held high through reset release raises nothing.
    a_lines = 8'h40;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
    chk("t4_no_pend", a_pending, 8'h00);
    a_lines = 8'h00;
    tick();
    a_lines = 8'h40;
    tick();
    chk("t4_pend_after_rise", a_pending, 8'h40);

    // Stray ack in IDLE, stray EOI in ARMED.
    ack_a();
    chk("t5_stray_ack_valid", a_valid, 0);
    chk("t5_stray_ack_number", a_number, 16'h0000);
    chk("t5_stray_ack_pend", a_pending, 8'h40);
    write_mask(8'h40);
    tick();
    chk("t5_armed", a_active, 1);
    eoi_a();
    chk("t5_stray_eoi", a_active, 1);
    ack_a();
    chk("t5_number", a_number, 16'h0016);
    tick();
    // Reset during WAIT_EOI.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_active", a_active, 0);
    chk("t5_rst_number", a_number, 16'h0000);
    chk("t5_rst_valid", a_valid, 0);
    chk("t5_rst_pending", a_pending, 8'h00);
    chk("t5_rst_mask", a_mask, 8'h00);

    // New edge on the winner in the ack cycle keeps it pending.
    a_lines = 8'h00;
    write_mask(8'hFF);
    a_lines = 8'h01;
    tick();
    a_lines = 8'h00;
    tick();
    chk("t6_armed", a_active, 1);
    a_lines = 8'h01;
    ack_a();
    chk("t6_number", a_number, 16'h0010);
    chk("t6_set_wins", a_pending, 8'h01);
    a_lines = 8'h00;
    tick();
    eoi_a();
    tick();
    chk("t6_rearm", a_active, 1);
    // Mask write in the ack cycle: winner chosen with the old mask.
    a_mask_we   = 1'b1;
    a_mask_data = 8'h00;
    a_ack       = 1'b1;
    tick();
    a_mask_we   = 1'b0;
    a_ack       = 1'b0;
    chk("t7_number", a_number, 16'h0010);
    chk("t7_valid", a_valid, 1);
    chk("t7_pend", a_pending, 8'h00);
    chk("t7_mask", a_mask, 8'h00);

    // Vector wrap on the 4-line instance.
    b_mask_we   = 1'b1;
    b_mask_data = 4'h8;
    tick();
    b_mask_we   = 1'b0;
    b_lines     = 4'h8;
    tick();
    b_lines     = 4'h0;
    tick();
    chk("t8_active", b_active, 1);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    chk("t8_wrap_number", b_number, 16'h0001);
    chk("t8_valid", b_valid, 1);
    chk("t8_pend", b_pending, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
